// File: rtl/reg_cmd_pkg.sv
// Shared definitions for the register-file command master: default widths,
// frame opcodes and the controller state encoding.
package reg_cmd_pkg;

  localparam int         DATA_W_DEF     = 8;
  localparam int         ADD_W_DEF      = 4;
  localparam int         RD_TIMEOUT_DEF = 8;
  localparam logic [7:0] WR_CMD_DEF     = 8'hAA;
  localparam logic [7:0] RD_CMD_DEF     = 8'hBB;

  // Frame-parsing states; TX_REQ is entered once a read response is held
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_ADDR = 3'd1,
    ST_WR_DATA = 3'd2,
    ST_RD_ADDR = 3'd3,
    ST_RD_WAIT = 3'd4,
    ST_TX_REQ  = 3'd5
  } state_t;

endpackage

// File: rtl/reg_cmd_ctrl_tx_handshake.sv
// Holds a response byte and presents it to the UART transmitter with a
// valid/busy handshake: request rises on the first non-busy cycle and is
// held, with stable data, until the transmitter reports busy.
module tx_handshake #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              busy,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_vld,
  output logic              done
);

  logic pending;

  // Capture the byte on load, then raise/hold/release the transmit request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= 1'b0;
      tx_vld  <= 1'b0;
      tx_data <= '0;
    end else if (load) begin
      tx_data <= load_data;
      pending <= 1'b1;
      tx_vld  <= 1'b0;
    end else if (pending) begin
      if (!tx_vld && !busy) begin
        tx_vld <= 1'b1;
      end else if (tx_vld && busy) begin
        tx_vld  <= 1'b0;
        pending <= 1'b0;
      end
    end
  end

  // The transmitter has accepted the byte on the edge that sees busy while
  // the request is up; the owner uses this to leave its response state.
  assign done = tx_vld && busy;

endmodule

// File: rtl/reg_cmd_ctrl.sv
// Command-side master for the register file. Parses AA/addr/data write
// frames and BB/addr read frames from the UART receiver, issues one-cycle
// WrEn/RdEn strobes, and forwards read data to the UART transmitter.
module reg_cmd_ctrl
  import reg_cmd_pkg::*;
#(
  parameter int                DATA_W     = DATA_W_DEF,
  parameter int                ADD_W      = ADD_W_DEF,
  parameter logic [DATA_W-1:0] WR_CMD     = WR_CMD_DEF,
  parameter logic [DATA_W-1:0] RD_CMD     = RD_CMD_DEF,
  parameter int                RD_TIMEOUT = RD_TIMEOUT_DEF
) (
  input  logic              Clk,
  input  logic              RST_n,
  input  logic [DATA_W-1:0] RX_P_Data,
  input  logic              RX_D_VLD,
  input  logic [DATA_W-1:0] RdData,
  input  logic              RdData_Valid,
  input  logic              TX_Busy,
  output logic              WrEn,
  output logic              RdEn,
  output logic [ADD_W-1:0]  Address,
  output logic [DATA_W-1:0] WrData,
  output logic [DATA_W-1:0] TX_P_Data,
  output logic              TX_D_VLD,
  output logic              Cmd_Err
);

  localparam int CNT_W = $clog2(RD_TIMEOUT + 1);

  state_t             state;
  logic [CNT_W-1:0]   rd_cnt;
  logic               wr_en;
  logic               rd_en;
  logic               cmd_err;
  logic [ADD_W-1:0]   address;
  logic [DATA_W-1:0]  wr_data;
  logic               addr_bad;
  logic               tx_load;
  logic               tx_done;

  // Address bytes with any bit above the register-file range are rejected
  assign addr_bad = (RX_P_Data[DATA_W-1:ADD_W] != '0);

  // A read response is only accepted while a read is outstanding
  assign tx_load = (state == ST_RD_WAIT) && RdData_Valid;

  // Frame parser, strobe generation and read-response timeout
  always_ff @(posedge Clk or negedge RST_n) begin
    if (!RST_n) begin
      state   <= ST_IDLE;
      rd_cnt  <= '0;
      wr_en   <= 1'b0;
      rd_en   <= 1'b0;
      cmd_err <= 1'b0;
      address <= '0;
      wr_data <= '0;
    end else begin
      wr_en   <= 1'b0;
      rd_en   <= 1'b0;
      cmd_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (RX_D_VLD) begin
            if (RX_P_Data == WR_CMD) begin
              state <= ST_WR_ADDR;
            end else if (RX_P_Data == RD_CMD) begin
              state <= ST_RD_ADDR;
            end else begin
              cmd_err <= 1'b1;
            end
          end
        end
        ST_WR_ADDR: begin
          if (RX_D_VLD) begin
            if (addr_bad) begin
              cmd_err <= 1'b1;
              state   <= ST_IDLE;
            end else begin
              address <= RX_P_Data[ADD_W-1:0];
              state   <= ST_WR_DATA;
            end
          end
        end
        ST_WR_DATA: begin
          if (RX_D_VLD) begin
            wr_data <= RX_P_Data;
            wr_en   <= 1'b1;
            state   <= ST_IDLE;
          end
        end
        ST_RD_ADDR: begin
          if (RX_D_VLD) begin
            if (addr_bad) begin
              cmd_err <= 1'b1;
              state   <= ST_IDLE;
            end else begin
              address <= RX_P_Data[ADD_W-1:0];
              rd_en   <= 1'b1;
              rd_cnt  <= '0;
              state   <= ST_RD_WAIT;
            end
          end
        end
        ST_RD_WAIT: begin
          // A byte arriving mid-read is dropped but flagged
          if (RX_D_VLD) begin
            cmd_err <= 1'b1;
          end
          if (RdData_Valid) begin
            state <= ST_TX_REQ;
          end else if (rd_cnt == CNT_W'(RD_TIMEOUT - 1)) begin
            cmd_err <= 1'b1;
            state   <= ST_IDLE;
          end else begin
            rd_cnt <= rd_cnt + 1'b1;
          end
        end
        ST_TX_REQ: begin
          if (RX_D_VLD) begin
            cmd_err <= 1'b1;
          end
          if (tx_done) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  tx_handshake #(
    .DATA_W (DATA_W)
  ) u_tx_handshake (
    .clk       (Clk),
    .rst_n     (RST_n),
    .load      (tx_load),
    .load_data (RdData),
    .busy      (TX_Busy),
    .tx_data   (TX_P_Data),
    .tx_vld    (TX_D_VLD),
    .done      (tx_done)
  );

  assign WrEn    = wr_en;
  assign RdEn    = rd_en;
  assign Cmd_Err = cmd_err;
  assign Address = address;
  assign WrData  = wr_data;

endmodule

// File: tb/tb_reg_cmd_ctrl.sv
// Bench for reg_cmd_ctrl: directed frame scenarios plus randomized frames
// checked against an abstract register-content model.
module tb_reg_cmd_ctrl;

  logic       Clk = 1'b0;
  logic       RST_n = 1'b0;
  logic [7:0] RX_P_Data = 8'h00;
  logic       RX_D_VLD = 1'b0;
  logic [7:0] RdData;
  logic       RdData_Valid;
  logic       TX_Busy = 1'b0;
  logic       WrEn;
  logic       RdEn;
  logic [3:0] Address;
  logic [7:0] WrData;
  logic [7:0] TX_P_Data;
  logic       TX_D_VLD;
  logic       Cmd_Err;

  int n_checks = 0;
  int n_fail   = 0;

  // pulse counters kept by the monitor
  int   wr_cnt = 0, rd_cnt = 0, err_cnt = 0, txv_cnt = 0, both_cnt = 0;
  logic prev_vld = 1'b0;

  // register-file environment model
  bit         rf_respond = 1'b1;
  logic [7:0] rf_mem [16];

  reg_cmd_ctrl dut (
    .Clk          (Clk),
    .RST_n        (RST_n),
    .RX_P_Data    (RX_P_Data),
    .RX_D_VLD     (RX_D_VLD),
    .RdData       (RdData),
    .RdData_Valid (RdData_Valid),
    .TX_Busy      (TX_Busy),
    .WrEn         (WrEn),
    .RdEn         (RdEn),
    .Address      (Address),
    .WrData       (WrData),
    .TX_P_Data    (TX_P_Data),
    .TX_D_VLD     (TX_D_VLD),
    .Cmd_Err      (Cmd_Err)
  );

  always #5 Clk = ~Clk;

  // register file: answers a read one cycle after RdEn, stores writes
  always @(posedge Clk or negedge RST_n) begin
    if (!RST_n) begin
      RdData_Valid <= 1'b0;
      RdData       <= 8'h00;
    end else begin
      RdData_Valid <= 1'b0;
      if (RdEn && rf_respond) begin
        RdData_Valid <= 1'b1;
        RdData       <= rf_mem[Address];
      end
      if (WrEn) rf_mem[Address] <= WrData;
    end
  end

  // pulse monitor, sampled mid-cycle
  always @(negedge Clk) begin
    if (WrEn) wr_cnt <= wr_cnt + 1;
    if (RdEn) rd_cnt <= rd_cnt + 1;
    if (Cmd_Err) err_cnt <= err_cnt + 1;
    if (WrEn && RdEn) both_cnt <= both_cnt + 1;
    if (TX_D_VLD && !prev_vld) txv_cnt <= txv_cnt + 1;
    prev_vld <= TX_D_VLD;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // one byte strobe; returns 1 time unit after the edge that sampled it
  task automatic send_byte(input logic [7:0] b);
    @(posedge Clk); #1;
    RX_P_Data = b;
    RX_D_VLD  = 1'b1;
    @(posedge Clk); #1;
    RX_D_VLD  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge Clk); #1; end
  endtask

  // act as the transmitter: wait for a request, keep busy low for `hold`
  // cycles, then raise busy for one cycle and observe the release
  task automatic tx_accept(input int hold, output logic [7:0] data,
                           output bit got, output bit stable, output bit dropped);
    got = 1'b0; stable = 1'b1; dropped = 1'b0; data = 8'hxx;
    for (int i = 0; i < 40 && !got; i++) begin
      @(posedge Clk); #1;
      if (TX_D_VLD) got = 1'b1;
    end
    if (got) begin
      data = TX_P_Data;
      for (int i = 0; i < hold; i++) begin
        @(posedge Clk); #1;
        if (!TX_D_VLD || TX_P_Data !== data) stable = 1'b0;
      end
      TX_Busy = 1'b1;
      @(posedge Clk); #1;
      dropped = !TX_D_VLD;
      TX_Busy = 1'b0;
    end
  endtask

  task automatic test_reset();
    logic [29:0] outs;
    RST_n = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    outs = {WrEn, RdEn, Address, WrData, TX_P_Data, TX_D_VLD, Cmd_Err};
    n_checks++;
    if (outs !== 30'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h expected 0", outs);
    end
    RST_n = 1'b1;
    idle(2);
    outs = {WrEn, RdEn, Address, WrData, TX_P_Data, TX_D_VLD, Cmd_Err};
    n_checks++;
    if (outs !== 30'd0) begin
      n_fail++;
      $display("FAIL post_reset_idle: got %h expected 0", outs);
    end
  endtask

  task automatic test_write();
    int w0, r0, t0, e0;
    w0 = wr_cnt; r0 = rd_cnt; t0 = txv_cnt; e0 = err_cnt;
    send_byte(8'hAA);
    send_byte(8'h05);
    n_checks++;
    if (WrEn !== 1'b0) begin
      n_fail++;
      $display("FAIL write_early: WrEn got %b expected 0 before data byte", WrEn);
    end
    send_byte(8'h3C);
    n_checks++;
    if ({WrEn, RdEn, Address, WrData} !== {1'b1, 1'b0, 4'h5, 8'h3C}) begin
      n_fail++;
      $display("FAIL write_strobe: got WrEn=%b RdEn=%b A=%h D=%h expected 1 0 5 3c",
               WrEn, RdEn, Address, WrData);
    end
    idle(1);
    n_checks++;
    if (WrEn !== 1'b0) begin
      n_fail++;
      $display("FAIL write_one_cycle: WrEn got %b expected 0", WrEn);
    end
    idle(3);
    n_checks++;
    if ({wr_cnt - w0, rd_cnt - r0, txv_cnt - t0, err_cnt - e0} !== {32'd1, 32'd0, 32'd0, 32'd0}) begin
      n_fail++;
      $display("FAIL write_counts: got wr=%0d rd=%0d tx=%0d err=%0d expected 1 0 0 0",
               wr_cnt - w0, rd_cnt - r0, txv_cnt - t0, err_cnt - e0);
    end
  endtask

  task automatic test_read();
    logic [7:0] d;
    bit got, stable, dropped;
    int r0, t0;
    send_byte(8'hAA); send_byte(8'h02); send_byte(8'h81);
    idle(2);
    r0 = rd_cnt; t0 = txv_cnt;
    send_byte(8'hBB);
    send_byte(8'h02);
    n_checks++;
    if ({RdEn, WrEn, Address} !== {1'b1, 1'b0, 4'h2}) begin
      n_fail++;
      $display("FAIL read_strobe: got RdEn=%b WrEn=%b A=%h expected 1 0 2", RdEn, WrEn, Address);
    end
    tx_accept(3, d, got, stable, dropped);
    n_checks++;
    if (!got || d !== 8'h81) begin
      n_fail++;
      $display("FAIL read_tx_data: got vld=%b data=%h expected 1 81", got, d);
    end
    n_checks++;
    if (!stable || !dropped) begin
      n_fail++;
      $display("FAIL read_tx_hold: got stable=%b dropped=%b expected 1 1", stable, dropped);
    end
    idle(3);
    n_checks++;
    if ({rd_cnt - r0, txv_cnt - t0, 31'd0, TX_D_VLD} !== {32'd1, 32'd1, 32'd0}) begin
      n_fail++;
      $display("FAIL read_counts: got rd=%0d tx=%0d vld=%b expected 1 1 0",
               rd_cnt - r0, txv_cnt - t0, TX_D_VLD);
    end
    // controller must be back in IDLE: a new write frame goes straight through
    send_byte(8'hAA); send_byte(8'h02); send_byte(8'h81);
    n_checks++;
    if (WrEn !== 1'b1) begin
      n_fail++;
      $display("FAIL read_back_to_idle: WrEn got %b expected 1", WrEn);
    end
  endtask

  task automatic test_busy_hold();
    logic [7:0] d;
    bit got, stable, dropped, early;
    early = 1'b0;
    TX_Busy = 1'b1;
    send_byte(8'hBB);
    send_byte(8'h02);
    for (int i = 0; i < 22; i++) begin
      @(posedge Clk); #1;
      if (TX_D_VLD) early = 1'b1;
    end
    n_checks++;
    if (early) begin
      n_fail++;
      $display("FAIL busy_hold_quiet: TX_D_VLD got 1 expected 0 while busy");
    end
    TX_Busy = 1'b0;
    tx_accept(2, d, got, stable, dropped);
    n_checks++;
    if (!got || d !== 8'h81 || !stable || !dropped) begin
      n_fail++;
      $display("FAIL busy_hold_tx: got vld=%b data=%h stable=%b dropped=%b expected 1 81 1 1",
               got, d, stable, dropped);
    end
  endtask

  task automatic test_errors();
    int w0, r0, e0;
    w0 = wr_cnt; r0 = rd_cnt; e0 = err_cnt;
    send_byte(8'h11);
    n_checks++;
    if (Cmd_Err !== 1'b1) begin
      n_fail++;
      $display("FAIL bad_opcode_err: Cmd_Err got %b expected 1", Cmd_Err);
    end
    idle(2);
    send_byte(8'hAA);
    send_byte(8'h10);
    n_checks++;
    if (Cmd_Err !== 1'b1) begin
      n_fail++;
      $display("FAIL addr_range_err: Cmd_Err got %b expected 1", Cmd_Err);
    end
    idle(2);
    n_checks++;
    if ({wr_cnt - w0, rd_cnt - r0, err_cnt - e0} !== {32'd0, 32'd0, 32'd2}) begin
      n_fail++;
      $display("FAIL error_counts: got wr=%0d rd=%0d err=%0d expected 0 0 2",
               wr_cnt - w0, rd_cnt - r0, err_cnt - e0);
    end
    send_byte(8'hAA); send_byte(8'h01); send_byte(8'h55);
    n_checks++;
    if ({WrEn, Address, WrData} !== {1'b1, 4'h1, 8'h55}) begin
      n_fail++;
      $display("FAIL write_after_err: got WrEn=%b A=%h D=%h expected 1 1 55", WrEn, Address, WrData);
    end
  endtask

  task automatic test_timeout();
    logic [7:0] d;
    bit got, stable, dropped, bad;
    int t0;
    send_byte(8'hAA); send_byte(8'h03); send_byte(8'hC5);
    idle(2);
    rf_respond = 1'b0;
    t0 = txv_cnt;
    bad = 1'b0;
    send_byte(8'hBB);
    send_byte(8'h03);
    for (int k = 1; k <= 10; k++) begin
      @(posedge Clk); #1;
      if (Cmd_Err !== (k == 8)) bad = 1'b1;
    end
    n_checks++;
    if (bad) begin
      n_fail++;
      $display("FAIL timeout_pulse: Cmd_Err not a single pulse 8 cycles after RdEn");
    end
    n_checks++;
    if ({txv_cnt - t0, TX_P_Data} !== {32'd0, 8'h81}) begin
      n_fail++;
      $display("FAIL timeout_no_tx: got tx=%0d data=%h expected 0 81", txv_cnt - t0, TX_P_Data);
    end
    rf_respond = 1'b1;
    send_byte(8'hBB);
    send_byte(8'h03);
    tx_accept(1, d, got, stable, dropped);
    n_checks++;
    if (!got || d !== 8'hC5 || !dropped) begin
      n_fail++;
      $display("FAIL read_after_timeout: got vld=%b data=%h dropped=%b expected 1 c5 1", got, d, dropped);
    end
  endtask

  task automatic test_reset_mid_frame();
    logic [29:0] outs;
    int w0;
    send_byte(8'hAA);
    send_byte(8'h07);
    @(posedge Clk); #1;
    RST_n = 1'b0;
    #1;
    outs = {WrEn, RdEn, Address, WrData, TX_P_Data, TX_D_VLD, Cmd_Err};
    n_checks++;
    if (outs !== 30'd0) begin
      n_fail++;
      $display("FAIL mid_reset_outputs: got %h expected 0", outs);
    end
    @(posedge Clk); #1;
    RST_n = 1'b1;
    w0 = wr_cnt;
    send_byte(8'h99);
    n_checks++;
    if ({Cmd_Err, WrEn} !== 2'b10) begin
      n_fail++;
      $display("FAIL stray_after_reset: got Cmd_Err=%b WrEn=%b expected 1 0", Cmd_Err, WrEn);
    end
    idle(3);
    n_checks++;
    if (wr_cnt != w0) begin
      n_fail++;
      $display("FAIL stray_no_write: got %0d writes expected 0", wr_cnt - w0);
    end
  endtask

  task automatic test_random();
    logic [7:0] exp_mem [16];
    bit         exp_ok  [16];
    logic [7:0] d, b;
    logic [3:0] a;
    bit got, stable, dropped;
    int kind;
    for (int i = 0; i < 16; i++) exp_ok[i] = 1'b0;
    for (int n = 0; n < 40; n++) begin
      kind = $urandom_range(0, 3);
      a = 4'($urandom_range(0, 15));
      if (kind == 1 && !exp_ok[a]) kind = 0;
      case (kind)
        0: begin
          d = 8'($urandom);
          send_byte(8'hAA); send_byte({4'h0, a}); send_byte(d);
          exp_mem[a] = d;
          exp_ok[a]  = 1'b1;
          n_checks++;
          if ({WrEn, Address, WrData} !== {1'b1, a, d}) begin
            n_fail++;
            $display("FAIL rand_write: got WrEn=%b A=%h D=%h expected 1 %h %h", WrEn, Address, WrData, a, d);
          end
        end
        1: begin
          send_byte(8'hBB); send_byte({4'h0, a});
          tx_accept($urandom_range(0, 3), d, got, stable, dropped);
          n_checks++;
          if (!got || d !== exp_mem[a] || !stable || !dropped) begin
            n_fail++;
            $display("FAIL rand_read: addr %h got vld=%b data=%h stable=%b expected 1 %h 1",
                     a, got, d, stable, exp_mem[a]);
          end
        end
        2: begin
          b = 8'($urandom);
          if (b == 8'hAA || b == 8'hBB) b = 8'h11;
          send_byte(b);
          n_checks++;
          if ({Cmd_Err, WrEn, RdEn} !== 3'b100) begin
            n_fail++;
            $display("FAIL rand_bad_op: byte %h got err/wr/rd=%b%b%b expected 100", b, Cmd_Err, WrEn, RdEn);
          end
        end
        default: begin
          b = 8'($urandom_range(16, 255));
          send_byte(($urandom_range(0, 1) != 0) ? 8'hAA : 8'hBB);
          send_byte(b);
          n_checks++;
          if ({Cmd_Err, WrEn, RdEn} !== 3'b100) begin
            n_fail++;
            $display("FAIL rand_bad_addr: addr %h got err/wr/rd=%b%b%b expected 100", b, Cmd_Err, WrEn, RdEn);
          end
        end
      endcase
      idle($urandom_range(1, 3));
    end
    n_checks++;
    if (both_cnt != 0) begin
      n_fail++;
      $display("FAIL strobe_exclusive: WrEn and RdEn high together %0d times expected 0", both_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_busy_hold();
    test_errors();
    test_timeout();
    test_reset_mid_frame();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
